// File: rtl/shared_count_arbiter_if.sv
// Bundle of the session control, request/grant and status signals of
// shared_count_arbiter.
//   master : drives start/req, observes grants and counter status
//   slave  : the arbiter itself
// Ports carried:
//   start      session start, sampled at posedge
//   req        per-requester increment request (level)
//   gnt        one-hot registered grant, high one cycle per grant
//   gnt_count  counter value after the granted increment
//   count      current shared counter value
//   grants     grants issued in the current session
//   busy/done  session running / session finished
interface shared_count_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100
);
    localparam int GW = $clog2(NUM_TESTS + 1);

    logic                 start;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [WIDTH-1:0]     gnt_count;
    logic [WIDTH-1:0]     count;
    logic [GW-1:0]        grants;
    logic                 busy;
    logic                 done;

    modport master (
        output start, req,
        input  gnt, gnt_count, count, grants, busy, done
    );

    modport slave (
        input  start, req,
        output gnt, gnt_count, count, grants, busy, done
    );
endinterface

// File: rtl/shared_count_arbiter.sv
// Round-robin arbiter owning a single shared counter. Requesters ask for
// increments through req; each grant bumps the counter by one on a single
// registered edge. A session of NUM_TESTS grants is run after start, then
// the block parks in DONE until started again.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    shared_count_arbiter_if.slave (start, req, gnt, gnt_count,
//          count, grants, busy, done)
module shared_count_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shared_count_arbiter_if.slave   bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int GW = $clog2(NUM_TESTS + 1);
    localparam logic [PW:0]   NREQ_W    = (PW + 1)'(NUM_REQ);
    localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);
    localparam logic [GW-1:0] LAST_GNT  = GW'(NUM_TESTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]     gnt_count_q, gnt_count_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [GW-1:0]        grants_q, grants_d;
    logic                 busy_q, done_q;

    logic                 found;
    logic [PW-1:0]        win;
    logic [PW:0]          sum;

    // Round-robin scan: offsets 1..NUM_REQ from the last winner; the sum
    // stays below 2*NUM_REQ, so one conditional subtract gives the modulo.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            sum = (PW + 1)'(ptr_q) + (PW + 1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            if (!found && bus.req[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        gnt_count_d = gnt_count_q;
        count_d     = count_q;
        grants_d    = grants_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_RUN;
                    count_d  = '0;
                    grants_d = '0;
                    ptr_d    = PTR_RESET;
                end
            end
            S_RUN: begin
                if (found) begin
                    gnt_d       = NUM_REQ'(1) << win;
                    count_d     = count_q + 1'b1;
                    gnt_count_d = count_q + 1'b1;
                    grants_d    = grants_q + 1'b1;
                    ptr_d       = win;
                    if (grants_q == LAST_GNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_RESET;
            gnt_q       <= '0;
            gnt_count_q <= '0;
            count_q     <= '0;
            grants_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_count_q <= gnt_count_d;
            count_q     <= count_d;
            grants_q    <= grants_d;
            busy_q      <= (state_d == S_RUN);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_count = gnt_count_q;
    assign bus.count     = count_q;
    assign bus.grants    = grants_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shared_count_arbiter.sv
module tb_shared_count_arbiter;
    logic clk;
    logic rst_n;

    shared_count_arbiter_if #(.NUM_REQ(4), .WIDTH(8), .NUM_TESTS(100)) if_a ();
    shared_count_arbiter_if #(.NUM_REQ(4), .WIDTH(4), .NUM_TESTS(20))  if_b ();

    shared_count_arbiter #(.NUM_REQ(4), .WIDTH(8), .NUM_TESTS(100)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
    );
    shared_count_arbiter #(.NUM_REQ(4), .WIDTH(4), .NUM_TESTS(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Session-level model: state 0=idle 1=run 2=done
    typedef struct {
        int st;
        int cnt;
        int grs;
        int ptr;
        int gnt;
        int gcnt;
    } ms_t;

    function automatic ms_t mreset(input int nreq);
        ms_t m;
        m.st = 0; m.cnt = 0; m.grs = 0; m.ptr = nreq - 1; m.gnt = 0; m.gcnt = 0;
        return m;
    endfunction

    function automatic ms_t mstep(input ms_t m, input bit s, input int req,
                                  input int nreq, input int w, input int nt);
        ms_t n = m;
        n.gnt = 0;
        if (m.st != 1) begin
            if (s) begin
                n.st = 1; n.cnt = 0; n.grs = 0; n.ptr = nreq - 1;
            end
        end else if (req != 0) begin
            int i = m.ptr;
            do i = (i + 1) % nreq; while (((req >> i) & 1) == 0);
            n.gnt  = 1 << i;
            n.cnt  = (m.cnt + 1) % (1 << w);
            n.gcnt = n.cnt;
            n.grs  = m.grs + 1;
            n.ptr  = i;
            if (n.grs == nt) n.st = 2;
        end
        return n;
    endfunction

    ms_t ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mreset(4);
            mb = mreset(4);
        end else begin
            ma = mstep(ma, if_a.start, int'(if_a.req), 4, 8, 100);
            mb = mstep(mb, if_b.start, int'(if_b.req), 4, 4, 20);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_gnt",    int'(if_a.gnt),       ma.gnt);
            chk("a_gcnt",   int'(if_a.gnt_count), ma.gcnt);
            chk("a_count",  int'(if_a.count),     ma.cnt);
            chk("a_grants", int'(if_a.grants),    ma.grs);
            chk("a_busy",   int'(if_a.busy),      int'(ma.st == 1));
            chk("a_done",   int'(if_a.done),      int'(ma.st == 2));
            chk("b_gnt",    int'(if_b.gnt),       mb.gnt);
            chk("b_gcnt",   int'(if_b.gnt_count), mb.gcnt);
            chk("b_count",  int'(if_b.count),     mb.cnt);
            chk("b_grants", int'(if_b.grants),    mb.grs);
            chk("b_busy",   int'(if_b.busy),      int'(mb.st == 1));
            chk("b_done",   int'(if_b.done),      int'(mb.st == 2));
            if (mb.st != 0)
                chk("b_inv", int'(if_b.count), int'(if_b.grants) % 16);
        end
    end

    task automatic drive_a(input bit s, input logic [3:0] r);
        if_a.start = s;
        if_a.req   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input bit s, input logic [3:0] r);
        if_b.start = s;
        if_b.req   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero();
        chk("rst_a_gnt",    int'(if_a.gnt),       0);
        chk("rst_a_gcnt",   int'(if_a.gnt_count), 0);
        chk("rst_a_count",  int'(if_a.count),     0);
        chk("rst_a_grants", int'(if_a.grants),    0);
        chk("rst_a_busy",   int'(if_a.busy),      0);
        chk("rst_a_done",   int'(if_a.done),      0);
        chk("rst_b_count",  int'(if_b.count),     0);
        chk("rst_b_busy",   int'(if_b.busy),      0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        if_a.start = 1'b0;
        if_a.req   = '0;
        if_b.start = 1'b0;
        if_b.req   = '0;
        do_reset();

        // Single requester held for five grants
        drive_a(1'b1, 4'b0000);
        chk("t1_busy", int'(if_a.busy), 1);
        chk("t1_gnt0", int'(if_a.gnt), 0);
        for (int k = 1; k <= 5; k++) begin
            drive_a(1'b0, 4'b0010);
            chk("t1_gnt",  int'(if_a.gnt), 2);
            chk("t1_gcnt", int'(if_a.gnt_count), k);
        end
        chk("t1_count",  int'(if_a.count), 5);
        chk("t1_grants", int'(if_a.grants), 5);

        // Reset mid-session, then full rotation starting at requester 0
        do_reset();
        drive_a(1'b1, 4'b1111);
        chk("t2_first_edge", int'(if_a.gnt), 0);
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b0, 4'b1111);
            chk("t2_gnt",   int'(if_a.gnt), 1 << (k % 4));
            chk("t2_count", int'(if_a.count), k + 1);
        end

        // Late requester 0 joins a 1010 stream
        do_reset();
        drive_a(1'b1, 4'b0000);
        drive_a(1'b0, 4'b1010); chk("t3_g1", int'(if_a.gnt), 2);
        drive_a(1'b0, 4'b1010); chk("t3_g2", int'(if_a.gnt), 8);
        drive_a(1'b0, 4'b1011); chk("t3_g3", int'(if_a.gnt), 1);
        drive_a(1'b0, 4'b1011); chk("t3_g4", int'(if_a.gnt), 2);
        drive_a(1'b0, 4'b1011); chk("t3_g5", int'(if_a.gnt), 8);

        // Full session of 100 grants
        do_reset();
        drive_a(1'b1, 4'b1111);
        for (int k = 0; k < 100; k++) begin
            drive_a(1'b0, 4'b1111);
            chk("t4_gnt",  int'(if_a.gnt), 1 << (k % 4));
            chk("t4_gcnt", int'(if_a.gnt_count), k + 1);
        end
        chk("t4_done",   int'(if_a.done), 1);
        chk("t4_busy",   int'(if_a.busy), 0);
        chk("t4_count",  int'(if_a.count), 100);
        chk("t4_grants", int'(if_a.grants), 100);
        drive_a(1'b0, 4'b1111);
        chk("t4_gnt_after",   int'(if_a.gnt), 0);
        chk("t4_count_after", int'(if_a.count), 100);
        chk("t4_gcnt_hold",   int'(if_a.gnt_count), 100);
        drive_a(1'b1, 4'b1111);
        chk("t4_restart_busy",  int'(if_a.busy), 1);
        chk("t4_restart_count", int'(if_a.count), 0);
        chk("t4_restart_gnt",   int'(if_a.gnt), 0);
        drive_a(1'b0, 4'b1111);
        chk("t4_first_gnt", int'(if_a.gnt), 1);
        chk("t4_first_cnt", int'(if_a.count), 1);
        drive_a(1'b0, 4'b0000);
        chk("t4_idle_req", int'(if_a.gnt), 0);
        chk("t4_idle_cnt", int'(if_a.count), 1);

        // Narrow counter wraps during a 20-grant session
        drive_b(1'b1, 4'b0000);
        for (int k = 1; k <= 20; k++) begin
            drive_b(1'b0, 4'b1111);
            if (k == 15) chk("t5_cnt15", int'(if_b.count), 15);
            if (k == 16) chk("t5_wrap",  int'(if_b.count), 0);
        end
        chk("t5_count",  int'(if_b.count), 4);
        chk("t5_grants", int'(if_b.grants), 20);
        chk("t5_done",   int'(if_b.done), 1);
        drive_b(1'b1, 4'b0000);
        chk("t5_rs_count",  int'(if_b.count), 0);
        chk("t5_rs_grants", int'(if_b.grants), 0);
        chk("t5_rs_busy",   int'(if_b.busy), 1);
        drive_b(1'b0, 4'b0000);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
